// File: rtl/alu_issue_queue.sv
// ALU issue queue: FIFO of decoded ALU ops, head presentation, write-back tagging.
// Optional same-cycle bypass into an empty queue: define ISSUE_BYPASS_EN.
module alu_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int MULDIV_GAP = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [2:0]               i_op_mode,
    input  logic [2:0]               i_func_op,
    input  logic                     i_fp_mode,
    input  logic [31:0]              i_a,
    input  logic [31:0]              i_b,
    input  logic [4:0]               i_rd,
    output logic [2:0]               o_alu_op_mode,
    output logic [2:0]               o_alu_func_op,
    output logic                     o_alu_fp_mode,
    output logic [31:0]              o_alu_a,
    output logic [31:0]              o_alu_b,
    output logic                     o_alu_stall,
    input  logic                     i_alu_stall,
    output logic                     o_wb_valid,
    output logic [4:0]               o_wb_rd,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(MULDIV_GAP + 1);

    typedef struct packed {
        logic [2:0]  mode;
        logic [2:0]  func;
        logic        fp;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } uop_t;

    uop_t          mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [BW-1:0] bubble;

    uop_t in_op;
    uop_t cur;
    logic push;
    logic byp;
    logic present;
    logic issue;
    logic wr;
    logic rd_pop;
    logic is_md;

    assign in_op = '{mode: i_op_mode, func: i_func_op, fp: i_fp_mode,
                     a: i_a, b: i_b, rd: i_rd};

    assign o_ready = (count != (PW+1)'(DEPTH));
    assign push    = i_valid & o_ready & ~i_flush;
    assign o_count = count;

`ifdef ISSUE_BYPASS_EN
    assign byp = (count == '0) & (bubble == '0) & push;
`else
    assign byp = 1'b0;
`endif

    assign present = ((count != '0) & (bubble == '0)) | byp;
    assign cur     = byp ? in_op : mem[head];
    assign issue   = present & ~i_alu_stall;
    // A bypassed op that issues at once never occupies a slot
    assign wr      = push & ~(byp & issue);
    assign rd_pop  = issue & ~byp;
    assign is_md   = cur.mode[2] & (cur.mode[1] | cur.mode[0]);

    always_comb begin
        o_alu_op_mode = '0;
        o_alu_func_op = '0;
        o_alu_fp_mode = 1'b0;
        o_alu_a       = '0;
        o_alu_b       = '0;
        o_alu_stall   = 1'b1;
        if (present) begin
            o_alu_op_mode = cur.mode;
            o_alu_func_op = cur.func;
            o_alu_fp_mode = cur.fp;
            o_alu_a       = cur.a;
            o_alu_b       = cur.b;
            o_alu_stall   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem[tail] <= in_op;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            bubble     <= '0;
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
        end else if (i_flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            bubble     <= '0;
            o_wb_valid <= 1'b0;
        end else begin
            if (wr) begin
                tail <= tail + PW'(1);
            end
            if (rd_pop) begin
                head <= head + PW'(1);
            end
            count <= count + (PW+1)'(wr) - (PW+1)'(rd_pop);
            // Idle gap lets the ALU see a fresh mode edge for the next start
            if (issue & is_md) begin
                bubble <= BW'(MULDIV_GAP);
            end else if (bubble != '0) begin
                bubble <= bubble - BW'(1);
            end
            o_wb_valid <= issue;
            if (issue) begin
                o_wb_rd <= cur.rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a cycle model and scoreboard queue.
// Builds with or without ISSUE_BYPASS_EN.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;
`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [2:0]  mode;
        logic [2:0]  func;
        logic        fp;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op_mode = '0;
    logic [2:0]  i_func_op = '0;
    logic        i_fp_mode = 1'b0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic [4:0]  i_rd = '0;
    logic [2:0]  o_alu_op_mode;
    logic [2:0]  o_alu_func_op;
    logic        o_alu_fp_mode;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        o_alu_stall;
    logic        i_alu_stall = 1'b0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [2:0]  o_count;

    int   total = 0;
    int   bad = 0;
    op_t  q[$];
    int   bub = 0;
    bit   ewv = 1'b0;
    logic [4:0] ewrd = '0;

    alu_issue_queue #(.DEPTH(DEPTH), .MULDIV_GAP(GAP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_op_mode(i_op_mode), .i_func_op(i_func_op),
        .i_fp_mode(i_fp_mode), .i_a(i_a), .i_b(i_b), .i_rd(i_rd),
        .o_alu_op_mode(o_alu_op_mode), .o_alu_func_op(o_alu_func_op),
        .o_alu_fp_mode(o_alu_fp_mode), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .o_alu_stall(o_alu_stall),
        .i_alu_stall(i_alu_stall), .o_wb_valid(o_wb_valid),
        .o_wb_rd(o_wb_rd), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic st,
                         input logic fl);
        i_valid     = v;
        i_op_mode   = m;
        i_func_op   = rd[2:0];
        i_fp_mode   = a[0];
        i_a         = a;
        i_b         = b;
        i_rd        = rd;
        i_alu_stall = st;
        i_flush     = fl;
    endtask

    // Check outputs at the negedge, then advance the model across the edge
    task automatic finish_step();
        op_t h;
        op_t inc;
        bit  push;
        bit  pres;
        bit  byp;
        bit  iss;
        @(negedge i_clk);
        chk("count", 32'(o_count), 32'(q.size()));
        chk("ready", 32'(o_ready), 32'(q.size() != DEPTH));
        chk("wb_valid", 32'(o_wb_valid), 32'(ewv));
        if (ewv) chk("wb_rd", 32'(o_wb_rd), 32'(ewrd));
        inc  = '{mode: i_op_mode, func: i_func_op, fp: i_fp_mode,
                 a: i_a, b: i_b, rd: i_rd};
        push = i_valid && (q.size() != DEPTH) && !i_flush;
        pres = 1'b0;
        byp  = 1'b0;
        h    = inc;
        if (q.size() != 0 && bub == 0) begin
            pres = 1'b1;
            h    = q[0];
        end else if (BYP && q.size() == 0 && bub == 0 && push) begin
            pres = 1'b1;
            byp  = 1'b1;
        end
        chk("alu_stall", 32'(o_alu_stall), 32'(!pres));
        if (pres) begin
            chk("alu_mode", 32'(o_alu_op_mode), 32'(h.mode));
            chk("alu_func", 32'(o_alu_func_op), 32'(h.func));
            chk("alu_fp", 32'(o_alu_fp_mode), 32'(h.fp));
            chk("alu_a", o_alu_a, h.a);
            chk("alu_b", o_alu_b, h.b);
        end else begin
            chk("idle_mode", 32'(o_alu_op_mode), 32'd0);
            chk("idle_a", o_alu_a, 32'd0);
        end
        iss = pres && !i_alu_stall;
        if (i_flush) begin
            q.delete();
            bub = 0;
            ewv = 1'b0;
        end else begin
            ewv = iss;
            if (iss) ewrd = h.rd;
            if (iss && !byp) void'(q.pop_front());
            if (push && !(byp && iss)) q.push_back(inc);
            if (iss && h.mode >= 3'd5) bub = GAP;
            else if (bub > 0) bub--;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic st,
                        input logic fl);
        drive(v, m, a, b, rd, st, fl);
        finish_step();
    endtask

    task automatic idle(input logic st);
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, st, 1'b0);
    endtask

    initial begin
        #2;
        i_rst_n = 1'b0;
        #10;
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_wbv", 32'(o_wb_valid), 32'd0);
        chk("rst_wbrd", 32'(o_wb_rd), 32'd0);
        chk("rst_stall", 32'(o_alu_stall), 32'd1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // ADD 5+7 -> rd3
        step(1'b1, 3'd4, 32'd5, 32'd7, 5'd3, 1'b0, 1'b0);
`ifndef ISSUE_BYPASS_EN
        chk("t1_pres", 32'(o_alu_stall), 32'd0);
        chk("t1_sum", o_alu_a + o_alu_b, 32'd12);
`endif
        idle(1'b0);
        chk("t1_wbv", 32'(o_wb_valid), BYP ? 32'd0 : 32'd1);
        chk("t1_wbrd", 32'(o_wb_rd), 32'd3);
        idle(1'b0);

        // Fill to full under stall; 5th op waits
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'd1, 32'(i + 1), 32'(i + 2), 5'(10 + i), 1'b1, 1'b0);
        chk("t2_full_cnt", 32'(o_count), 32'd4);
        chk("t2_full_rdy", 32'(o_ready), 32'd0);
        step(1'b1, 3'd2, 32'h55, 32'h3, 5'd14, 1'b1, 1'b0);
        step(1'b1, 3'd2, 32'h55, 32'h3, 5'd14, 1'b0, 1'b0);
        chk("t2_pop_cnt", 32'(o_count), 32'd3);
        step(1'b1, 3'd2, 32'h55, 32'h3, 5'd14, 1'b1, 1'b0);
        chk("t2_refill", 32'(o_count), 32'd4);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // MUL rd1, MUL rd2 with 3 stall cycles each
        step(1'b1, 3'd5, 32'd3, 32'd4, 5'd1, 1'b1, 1'b0);
        step(1'b1, 3'd5, 32'd6, 32'd7, 5'd2, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("t3_bubble", 32'(o_alu_stall), 32'd1);
        chk("t3_wb1", 32'(o_wb_rd), 32'd1);
        idle(1'b1);
        chk("t3_mul2", 32'(o_alu_op_mode), 32'd5);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("t3_wb2", 32'(o_wb_rd), 32'd2);
        idle(1'b0);
        idle(1'b0);

        // Flush beats concurrent push and pop
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd3, 32'(i), 32'd9, 5'(20 + i), 1'b1, 1'b0);
        step(1'b1, 3'd4, 32'd1, 32'd1, 5'd30, 1'b0, 1'b1);
        chk("t4_cnt", 32'(o_count), 32'd0);
        chk("t4_wbv", 32'(o_wb_valid), 32'd0);
        chk("t4_rdy", 32'(o_ready), 32'd1);
        idle(1'b0);

        // Streaming with random stalls across pointer wrap
        for (int i = 0; i < 24; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)),
                 $urandom, $urandom, 5'(i), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 16; i++) idle(1'b0);

        // Async reset in the middle of a DIV
        step(1'b1, 3'd6, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
        idle(1'b1);
        chk("t5_div", 32'(o_alu_op_mode), 32'd6);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t5_cnt", 32'(o_count), 32'd0);
        chk("t5_wbv", 32'(o_wb_valid), 32'd0);
        chk("t5_mode", 32'(o_alu_op_mode), 32'd0);
        chk("t5_stall", 32'(o_alu_stall), 32'd1);
        q.delete();
        bub = 0;
        ewv = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(1'b0);

`ifdef ISSUE_BYPASS_EN
        // SUB 9-4 -> rd7 presented in the push cycle
        drive(1'b1, 3'd4, 32'd9, 32'd4, 5'd7, 1'b0, 1'b0);
        #1;
        chk("t6_pres", 32'(o_alu_stall), 32'd0);
        chk("t6_diff", o_alu_a - o_alu_b, 32'd5);
        finish_step();
        chk("t6_wbv", 32'(o_wb_valid), 32'd1);
        chk("t6_wbrd", 32'(o_wb_rd), 32'd7);
        chk("t6_cnt", 32'(o_count), 32'd0);
        idle(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
